// File: rtl/fp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_accum_seq
// Description : Sequential reduction front-end for a combinational IEEE-754
//               single-precision adder. Operands arrive over a valid/ready
//               handshake. The running accumulator and the current operand
//               are presented to the adder, and the adder's sum is captured
//               after ADD_LAT stable cycles. On the operand flagged last, the
//               reduced sum and the element count are offered downstream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W    width of the element counter / out_count (saturating)
//   ADD_LAT  cycles the adder inputs are held before add_sum is captured
//            (legal range 1..4)
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   in_data, in_last      operand and end-of-vector flag, sampled together
//   add_a, add_b          to the adder: accumulator and operand registers
//   add_sum               from the adder
//   out_valid/out_ready   result handshake
//   out_data, out_count   reduced sum (accumulator) and operand count
// Optional feature
//   FP_ACC_ZERO_SKIP_EN   when defined, a non-first operand equal to +/-0
//                         bypasses the adder and costs a single cycle.
// ============================================================================
module fp_accum_seq #(
    parameter int CNT_W   = 16,
    parameter int ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    // Two bits cover the whole legal settle range (reload value 0..3).
    localparam int               LAT_W      = 2;
    localparam logic [LAT_W-1:0] C_LAT_LOAD = LAT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [31:0]        r_acc,       w_acc_nxt;
    logic [31:0]        r_opnd,      w_opnd_nxt;
    logic [CNT_W-1:0]   r_count,     w_count_nxt;
    logic               r_first,     w_first_nxt;
    logic               r_last_pend, w_last_pend_nxt;
    logic [LAT_W-1:0]   r_lat_cnt,   w_lat_cnt_nxt;

    logic               w_accept;
    logic [CNT_W-1:0]   w_count_inc;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    // Counter sticks at all-ones instead of wrapping.
    assign w_count_inc = (r_count == C_CNT_MAX) ? r_count : (r_count + 1'b1);

`ifdef FP_ACC_ZERO_SKIP_EN
    logic w_is_zero;
    // Sign bit ignored so that both +0 and -0 are skipped.
    assign w_is_zero = (in_data[30:0] == 31'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= 32'd0;
            r_opnd      <= 32'd0;
            r_count     <= '0;
            r_first     <= 1'b1;
            r_last_pend <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_opnd      <= w_opnd_nxt;
            r_count     <= w_count_nxt;
            r_first     <= w_first_nxt;
            r_last_pend <= w_last_pend_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_opnd_nxt      = r_opnd;
        w_count_nxt     = r_count;
        w_first_nxt     = r_first;
        w_last_pend_nxt = r_last_pend;
        w_lat_cnt_nxt   = r_lat_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (r_first) begin
                        // First operand seeds the accumulator directly; the
                        // adder is not involved.
                        w_acc_nxt   = in_data;
                        w_count_nxt = C_CNT_ONE;
                        w_first_nxt = 1'b0;
                        if (in_last) begin
                            w_state_nxt = S_DONE;
                        end
                    end
`ifdef FP_ACC_ZERO_SKIP_EN
                    else if (w_is_zero) begin
                        // Adding zero leaves the accumulator unchanged, so
                        // only the count moves and the adder is skipped.
                        w_count_nxt = w_count_inc;
                        if (in_last) begin
                            w_state_nxt = S_DONE;
                        end
                    end
`endif
                    else begin
                        w_opnd_nxt      = in_data;
                        w_last_pend_nxt = in_last;
                        w_lat_cnt_nxt   = C_LAT_LOAD;
                        w_state_nxt     = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // acc and opnd are not touched here, keeping the adder
                // inputs stable for the whole settle window.
                if (r_lat_cnt != '0) begin
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                end else begin
                    w_acc_nxt   = add_sum;
                    w_count_nxt = w_count_inc;
                    w_state_nxt = r_last_pend ? S_DONE : S_IDLE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    // acc is kept; the next first operand overwrites it.
                    w_state_nxt     = S_IDLE;
                    w_first_nxt     = 1'b1;
                    w_count_nxt     = '0;
                    w_last_pend_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign add_a     = r_acc;
    assign add_b     = r_opnd;
    assign out_data  = r_acc;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_accum_seq
// Description : Self-checking bench for fp_accum_seq. Three instances:
//               unit 0 (ADD_LAT=1), unit 1 (ADD_LAT=3) and unit 2
//               (ADD_LAT=1, CNT_W=2 for counter saturation). Each instance
//               is paired with a behavioural adder whose output is only
//               correct once its inputs have been stable ADD_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_accum_seq;

    localparam int          NU  = 3;
    localparam logic [31:0] BAD = 32'h7F70_0BAD;
`ifdef FP_ACC_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [NU];
    logic        in_ready  [NU];
    logic        in_last   [NU];
    logic        out_valid [NU];
    logic        out_ready [NU];
    logic [31:0] in_data   [NU];
    logic [31:0] add_a     [NU];
    logic [31:0] add_b     [NU];
    logic [31:0] add_sum   [NU];
    logic [31:0] out_data  [NU];
    logic [15:0] out_count [NU];
    logic [1:0]  cnt_small;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_accum_seq #(.CNT_W(16), .ADD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(add_sum[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_count(out_count[0])
    );

    fp_accum_seq #(.CNT_W(16), .ADD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(add_sum[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_count(out_count[1])
    );

    fp_accum_seq #(.CNT_W(2), .ADD_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
        .add_a(add_a[2]), .add_b(add_b[2]), .add_sum(add_sum[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_count(cnt_small)
    );
    assign out_count[2] = {14'd0, cnt_small};

    function automatic int lat_of(input int u);
        return (u == 1) ? 3 : 1;
    endfunction

    function automatic int cmax(input int u);
        return (u == 2) ? 3 : 65535;
    endfunction

    // Exact conversions for normal values and zero (the only values used).
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = 11'(int'(f[30:23]) - 127 + 1023);
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [7:0]  e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = 8'(int'(d[62:52]) - 1023 + 127);
        return {d[63], e, d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Adder model: output is garbage until a/b have been stable ADD_LAT cycles.
    int          stab [NU];
    logic [63:0] prev [NU];
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if ({add_a[u], add_b[u]} !== prev[u]) stab[u] <= 1;
            else                                  stab[u] <= stab[u] + 1;
            prev[u] <= {add_a[u], add_b[u]};
        end
    end
    assign add_sum[0] = (stab[0] >= 1) ? fadd(add_a[0], add_b[0]) : BAD;
    assign add_sum[1] = (stab[1] >= 3) ? fadd(add_a[1], add_b[1]) : BAD;
    assign add_sum[2] = (stab[2] >= 1) ? fadd(add_a[2], add_b[2]) : BAD;

    // Expected reduction: a lone element passes unchanged, otherwise the
    // exact arithmetic sum of all elements.
    function automatic logic [31:0] ref_sum(input int n, input logic [31:0] v [16]);
        real s;
        if (n == 1) return v[0];
        s = 0.0;
        for (int i = 0; i < n; i++) s += f2r(v[i]);
        return r2f(s);
    endfunction

    function automatic int exp_lat(input int u, input bit first, input logic [31:0] d);
        if (first) return 1;
        if (SKIP && (d[30:0] == 31'd0)) return 1;
        return lat_of(u) + 1;
    endfunction

    // Offers one operand; lat = negedges after the accept edge until the block
    // is ready again or has a result; stable = adder inputs held meanwhile.
    task automatic push(input int u, input logic [31:0] d, input logic last,
                        output int lat, output bit stable);
        logic [63:0] snap;
        int guard;
        guard = 0;
        lat = -1;
        stable = 1'b1;
        @(negedge clk);
        while (!in_ready[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard < 50) begin
            in_valid[u] = 1'b1;
            in_data[u]  = d;
            in_last[u]  = last;
            @(posedge clk);
            #1;
            in_valid[u] = 1'b0;
            snap = {add_a[u], add_b[u]};
            for (int k = 1; k <= 50; k++) begin
                @(negedge clk);
                if (in_ready[u] || out_valid[u]) begin
                    lat = k;
                    break;
                end
                if ({add_a[u], add_b[u]} !== snap) stable = 1'b0;
            end
        end
    endtask

    task automatic take(input int u, output logic [31:0] d, output logic [15:0] c, output bit got);
        got = 1'b0;
        d = 32'hx;
        c = 16'hx;
        for (int k = 0; k < 50; k++) begin
            if (out_valid[u]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            d = out_data[u];
            c = out_count[u];
            out_ready[u] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[u] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < NU; u++) begin
            in_valid[u] = 1'b0; in_data[u] = 32'd0; in_last[u] = 1'b0; out_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            n_tests++;
            if ({in_ready[u], out_valid[u]} !== 2'b10 || add_a[u] !== 32'd0 || add_b[u] !== 32'd0 ||
                out_data[u] !== 32'd0 || out_count[u] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset u%0d: rdy=%b vld=%b a=%h b=%h data=%h cnt=%0d, want rdy=1 vld=0 rest 0",
                         u, in_ready[u], out_valid[u], add_a[u], add_b[u], out_data[u], out_count[u]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [31:0] v [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        int lat; bit st, got; logic [31:0] d; logic [15:0] c;
        for (int i = 0; i < 3; i++) begin
            push(0, v[i], (i == 2), lat, st);
            n_tests++;
            if (lat !== ((i == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL stream_lat op%0d: got %0d want %0d", i, lat, (i == 0) ? 1 : 2);
            end
        end
        take(0, d, c, got);
        n_tests++;
        if (!got || d !== 32'h40C00000 || c !== 16'd3) begin
            n_fail++;
            $display("FAIL stream_result: got=%b data=%h cnt=%0d want data=40c00000 cnt=3", got, d, c);
        end
    endtask

    task automatic test_single();
        int lat; bit st, got; logic [31:0] d, b0; logic [15:0] c;
        @(negedge clk);
        b0 = add_b[0];
        push(0, 32'h3FC00000, 1'b1, lat, st);
        n_tests++;
        if (lat !== 1 || add_b[0] !== b0) begin
            n_fail++;
            $display("FAIL single_lat: lat=%0d add_b=%h, want lat=1 add_b=%h", lat, add_b[0], b0);
        end
        take(0, d, c, got);
        n_tests++;
        if (!got || d !== 32'h3FC00000 || c !== 16'd1) begin
            n_fail++;
            $display("FAIL single_result: got=%b data=%h cnt=%0d want 3fc00000/1", got, d, c);
        end
    endtask

    task automatic test_lat3();
        int lat; bit st, got; logic [31:0] d; logic [15:0] c;
        push(1, 32'h3F000000, 1'b0, lat, st);
        push(1, 32'h3F000000, 1'b1, lat, st);
        n_tests++;
        if (lat !== 4 || st !== 1'b1) begin
            n_fail++;
            $display("FAIL lat3_timing: lat=%0d stable=%b want lat=4 stable=1", lat, st);
        end
        take(1, d, c, got);
        n_tests++;
        if (!got || d !== 32'h3F800000 || c !== 16'd2) begin
            n_fail++;
            $display("FAIL lat3_result: got=%b data=%h cnt=%0d want 3f800000/2", got, d, c);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit st, got; logic [31:0] d; logic [15:0] c;
        push(0, 32'h3F800000, 1'b0, lat, st);
        push(0, 32'h40000000, 1'b1, lat, st);
        // Upstream already offers the next vector; it must wait.
        in_valid[0] = 1'b1; in_data[0] = 32'h12345678; in_last[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== 32'h40400000 ||
                out_count[0] !== 16'd2) begin
                n_fail++;
                $display("FAIL hold cyc%0d: vld=%b rdy=%b data=%h cnt=%0d want 1/0/40400000/2",
                         k, out_valid[0], in_ready[0], out_data[0], out_count[0]);
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_hs: vld=%b rdy=%b want 0/1", out_valid[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        take(0, d, c, got);
        n_tests++;
        if (!got || d !== 32'h12345678 || c !== 16'd1) begin
            n_fail++;
            $display("FAIL next_vec: got=%b data=%h cnt=%0d want 12345678/1", got, d, c);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit st, got; logic [31:0] d; logic [15:0] c;
        push(1, 32'h3F800000, 1'b0, lat, st);
        @(negedge clk);
        in_valid[1] = 1'b1; in_data[1] = 32'h40000000; in_last[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready[1], out_valid[1]} !== 2'b10 || add_a[1] !== 32'd0 || add_b[1] !== 32'd0 ||
            out_data[1] !== 32'd0 || out_count[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b vld=%b a=%h b=%h data=%h cnt=%0d want reset values",
                     in_ready[1], out_valid[1], add_a[1], add_b[1], out_data[1], out_count[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1, 32'h40000000, 1'b1, lat, st);
        take(1, d, c, got);
        n_tests++;
        if (!got || d !== 32'h40000000 || c !== 16'd1) begin
            n_fail++;
            $display("FAIL post_reset: got=%b data=%h cnt=%0d want 40000000/1", got, d, c);
        end
    endtask

    task automatic test_zero_skip();
        logic [31:0] v [3] = '{32'h3F800000, 32'h80000000, 32'h40000000};
        int lat, want; bit st, got; logic [31:0] d; logic [15:0] c;
        for (int i = 0; i < 3; i++) begin
            push(0, v[i], (i == 2), lat, st);
            want = (i == 0) ? 1 : ((i == 1 && SKIP) ? 1 : 2);
            n_tests++;
            if (lat !== want) begin
                n_fail++;
                $display("FAIL zero_lat op%0d: got %0d want %0d", i, lat, want);
            end
        end
        take(0, d, c, got);
        n_tests++;
        if (!got || d !== 32'h40400000 || c !== 16'd3) begin
            n_fail++;
            $display("FAIL zero_result: got=%b data=%h cnt=%0d want 40400000/3", got, d, c);
        end
    endtask

    task automatic test_saturate();
        int lat; bit st, got; logic [31:0] d; logic [15:0] c;
        for (int i = 0; i < 5; i++) push(2, 32'h3F800000, (i == 4), lat, st);
        take(2, d, c, got);
        n_tests++;
        if (!got || d !== 32'h40A00000 || c !== 16'd3) begin
            n_fail++;
            $display("FAIL saturate: got=%b data=%h cnt=%0d want 40a00000/3", got, d, c);
        end
    endtask

    function automatic logic [31:0] rnd_val(input bit first);
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 32'd0;
        if (k == 1 && !first) return 32'h80000000;
        return r2f((real'(int'($urandom_range(0, 400))) - 200.0) / 2.0);
    endfunction

    task automatic test_random();
        logic [31:0] v [16];
        int n, u, lat, want, wcnt; bit st, got; logic [31:0] d; logic [15:0] c;
        for (int it = 0; it < 30; it++) begin
            u = it % NU;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < 16; i++) v[i] = 32'd0;
            for (int i = 0; i < n; i++) v[i] = rnd_val(i == 0);
            for (int i = 0; i < n; i++) begin
                push(u, v[i], (i == n - 1), lat, st);
                want = exp_lat(u, (i == 0), v[i]);
                n_tests++;
                if (lat !== want || (want > 1 && st !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL rnd_timing it%0d op%0d: lat=%0d stable=%b want lat=%0d stable=1",
                             it, i, lat, st, want);
                end
            end
            take(u, d, c, got);
            wcnt = (n > cmax(u)) ? cmax(u) : n;
            n_tests++;
            if (!got || d !== ref_sum(n, v) || c !== 16'(wcnt)) begin
                n_fail++;
                $display("FAIL rnd_result it%0d u%0d: got=%b data=%h cnt=%0d want data=%h cnt=%0d",
                         it, u, got, d, c, ref_sum(n, v), wcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_single();
        test_lat3();
        test_backpressure();
        test_reset_mid();
        test_zero_skip();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
